// File: rtl/intf_stim_gen_if.sv
// intf_stim_gen_if: valid/ready beat channel carrying the stimulus value
// Ports (modports):
//   master - drives val, val_valid; samples val_ready
//   slave  - samples val, val_valid; drives val_ready
interface intf_stim_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] val;
    logic             val_valid;
    logic             val_ready;

    modport master (output val, output val_valid, input val_ready);
    modport slave  (input val, input val_valid, output val_ready);
endinterface

// File: rtl/intf_stim_gen.sv
// intf_stim_gen: emits COUNT beats of an arithmetic sequence over valid/ready,
// tracking a checksum and count of accepted beats.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start_i    - begins a sequence from IDLE or DONE
//   abort_i    - ends a running sequence, back to IDLE
//   bus        - master side of the beat channel (val, val_valid, val_ready)
//   checksum_o - sum of accepted beats mod 2^16
//   beat_cnt_o - accepted beats in the current or last sequence
//   done_o     - last sequence completed in full
//   tag_o      - constant PARAM[7:0]
module intf_stim_gen #(
    parameter int WIDTH = 8,
    parameter int COUNT = 16,
    parameter int SEED  = 0,
    parameter int STEP  = 1,
    parameter int PARAM = 0,
    localparam int CW   = $clog2(COUNT + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    intf_stim_gen_if.master        bus,
    output logic [15:0]            checksum_o,
    output logic [CW-1:0]          beat_cnt_o,
    output logic                   done_o,
    output logic [7:0]             tag_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [CW-1:0]    LAST   = CW'(COUNT - 1);

    state_t           state_q;
    logic [WIDTH-1:0] val_q;
    logic             valid_q;
    logic [15:0]      checksum_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic             xfer;

    assign xfer       = valid_q && bus.val_ready;
    assign bus.val       = val_q;
    assign bus.val_valid = valid_q;
    assign checksum_o = checksum_q;
    assign beat_cnt_o = cnt_q;
    assign done_o     = done_q;
    assign tag_o      = PARAM[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            val_q      <= '0;
            valid_q    <= 1'b0;
            checksum_q <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q    <= RUN;
                        val_q      <= SEED_W;
                        valid_q    <= 1'b1;
                        checksum_q <= '0;
                        cnt_q      <= '0;
                        done_q     <= 1'b0;
                    end
                end
                RUN: begin
                    // abort wins over a same-cycle transfer: that beat is dropped
                    if (abort_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (xfer) begin
                        checksum_q <= checksum_q + 16'(val_q);
                        cnt_q      <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            val_q <= val_q + STEP_W;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intf_stim_gen.sv
// tb_intf_stim_gen: table-driven check of intf_stim_gen plus reset and wrap sequences
module tb_intf_stim_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, abort_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0;
    logic [15:0] ck_a, ck_b;
    logic [2:0]  cnt_a, cnt_b;
    logic        done_a, done_b;
    logic [7:0]  tag_a, tag_b;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intf_stim_gen_if #(.WIDTH(8)) ifa ();
    intf_stim_gen_if #(.WIDTH(8)) ifb ();

    intf_stim_gen #(.WIDTH(8), .COUNT(4), .SEED(8'h10), .STEP(3), .PARAM(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a), .bus(ifa.master),
        .checksum_o(ck_a), .beat_cnt_o(cnt_a), .done_o(done_a), .tag_o(tag_a));

    intf_stim_gen #(.WIDTH(8), .COUNT(4), .SEED(8'hFE), .STEP(1), .PARAM(9)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b), .bus(ifb.master),
        .checksum_o(ck_b), .beat_cnt_o(cnt_b), .done_o(done_b), .tag_o(tag_b));

    typedef struct {
        logic       start;
        logic       abort;
        logic       ready;
        logic [7:0] val;
        logic       valid;
        logic [15:0] ck;
        logic [2:0] cnt;
        logic       done;
    } vec_t;

    vec_t vt[24];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string name, input vec_t v);
        chk({name, ".val"}, int'(ifa.val), int'(v.val));
        chk({name, ".valid"}, int'(ifa.val_valid), int'(v.valid));
        chk({name, ".ck"}, int'(ck_a), int'(v.ck));
        chk({name, ".cnt"}, int'(cnt_a), int'(v.cnt));
        chk({name, ".done"}, int'(done_a), int'(v.done));
    endtask

    initial begin
        logic [7:0] wrap_exp [4];
        // start abort ready | val valid ck cnt done  (state after the edge)
        vt[0]  = '{1,0,0, 8'h10,1,16'h00,0,0};
        vt[1]  = '{0,0,1, 8'h13,1,16'h10,1,0};
        vt[2]  = '{0,0,1, 8'h16,1,16'h23,2,0};
        vt[3]  = '{0,0,1, 8'h19,1,16'h39,3,0};
        vt[4]  = '{0,0,1, 8'h19,0,16'h52,4,1};
        vt[5]  = '{1,0,1, 8'h10,1,16'h00,0,0}; // restart in first DONE cycle
        vt[6]  = '{0,0,1, 8'h13,1,16'h10,1,0}; // backpressure 1,0,0,1,0,1,1
        vt[7]  = '{0,0,0, 8'h13,1,16'h10,1,0};
        vt[8]  = '{0,0,0, 8'h13,1,16'h10,1,0};
        vt[9]  = '{0,0,1, 8'h16,1,16'h23,2,0};
        vt[10] = '{0,0,0, 8'h16,1,16'h23,2,0};
        vt[11] = '{0,0,1, 8'h19,1,16'h39,3,0};
        vt[12] = '{0,0,1, 8'h19,0,16'h52,4,1};
        vt[13] = '{0,1,1, 8'h19,0,16'h52,4,1}; // abort/ready ignored in DONE
        vt[14] = '{1,0,0, 8'h10,1,16'h00,0,0};
        vt[15] = '{0,0,1, 8'h13,1,16'h10,1,0};
        vt[16] = '{0,0,1, 8'h16,1,16'h23,2,0};
        vt[17] = '{0,1,1, 8'h16,0,16'h23,2,0}; // abort beats 3rd transfer
        vt[18] = '{0,0,1, 8'h16,0,16'h23,2,0};
        vt[19] = '{1,0,0, 8'h10,1,16'h00,0,0}; // replay after abort
        vt[20] = '{1,0,1, 8'h13,1,16'h10,1,0}; // start in RUN ignored
        vt[21] = '{0,0,1, 8'h16,1,16'h23,2,0};
        vt[22] = '{0,0,1, 8'h19,1,16'h39,3,0};
        vt[23] = '{0,0,1, 8'h19,0,16'h52,4,1};
        wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};

        ifa.val_ready = 1'b0;
        ifb.val_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_a("reset", '{0,0,0, 8'h00,0,16'h0,0,0});
        chk("tag_a", int'(tag_a), 5);
        chk("tag_b", int'(tag_b), 9);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            start_a = vt[i].start;
            abort_a = vt[i].abort;
            ifa.val_ready = vt[i].ready;
            @(posedge clk);
            #1;
            chk_a($sformatf("vec%0d", i), vt[i]);
        end
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;

        // wrap-around on dut_b
        start_b = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start_b = 1'b0;
        ifb.val_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_beat%0d", i), int'(ifb.val), int'(wrap_exp[i]));
            chk($sformatf("wrap_valid%0d", i), int'(ifb.val_valid), 1);
            @(negedge clk);
        end
        chk("wrap_ck", int'(ck_b), 16'h01FE);
        chk("wrap_done", int'(done_b), 1);
        chk("wrap_valid_end", int'(ifb.val_valid), 0);

        // async reset mid-run after two accepted beats
        start_a = 1'b1;
        ifa.val_ready = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        chk_a("pre_rst", '{0,0,0, 8'h16,1,16'h23,2,0});
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("async_rst", '{0,0,0, 8'h00,0,16'h0,0,0});
        chk("async_rst_b_ck", int'(ck_b), 0);
        chk("async_rst_b_done", int'(done_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_a("post_rst_idle", '{0,0,0, 8'h00,0,16'h0,0,0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
